// File: rtl/m65_speed_governor_if.sv
// Speed governor signal bundle: speed selects, custom pace load, bus handshake
// inputs, and the pacing outputs back to the CPU core.
interface m65_speed_governor_if #(
    parameter int unsigned ACC_W = 16
);
    logic             force_fast;
    logic             hypervisor_mode;
    logic             speed_gate;
    logic             vicii_2mhz;
    logic             viciii_fast;
    logic             viciv_fast;
    logic             custom_en;
    logic             custom_we;
    logic [ACC_W-1:0] custom_inc;
    logic             bus_ready;
    logic             mapper_busy;
    logic             cpu_ready;
    logic             phi0;
    logic             phi_tick;
    logic [7:0]       cpuspeed;
    logic [3:0]       credit;

    // Driver side (CPU core / register file)
    modport master (
        output force_fast, hypervisor_mode, speed_gate,
        output vicii_2mhz, viciii_fast, viciv_fast,
        output custom_en, custom_we, custom_inc,
        output bus_ready, mapper_busy,
        input  cpu_ready, phi0, phi_tick, cpuspeed, credit
    );

    // Governor side
    modport slave (
        input  force_fast, hypervisor_mode, speed_gate,
        input  vicii_2mhz, viciii_fast, viciv_fast,
        input  custom_en, custom_we, custom_inc,
        input  bus_ready, mapper_busy,
        output cpu_ready, phi0, phi_tick, cpuspeed, credit
    );
endinterface

// File: rtl/m65_speed_governor.sv
// CPU speed governor: picks a pace from the speed selects, runs a phase
// accumulator whose carry grants pacing credit, and gates cpu_ready on that
// credit. A second free-running accumulator exports a fixed 1 MHz phi0.
module m65_speed_governor #(
    parameter int unsigned ACC_W      = 16,
    parameter int unsigned INC_1MHZ   = 1957,
    parameter int unsigned INC_2MHZ   = 3913,
    parameter int unsigned INC_3P5MHZ = 6848,
    parameter int unsigned CREDIT_MAX = 2
) (
    input logic                   clk,
    input logic                   reset,
    m65_speed_governor_if.slave   bus
);
    localparam logic [7:0] SpeedFull   = 8'h50;
    localparam logic [7:0] Speed1      = 8'h01;
    localparam logic [7:0] Speed2      = 8'h02;
    localparam logic [7:0] Speed3p5    = 8'h04;
    localparam logic [7:0] SpeedCustom = 8'hC0;

    localparam logic [ACC_W-1:0] Inc1   = ACC_W'(INC_1MHZ);
    localparam logic [ACC_W-1:0] Inc2   = ACC_W'(INC_2MHZ);
    localparam logic [ACC_W-1:0] Inc3p5 = ACC_W'(INC_3P5MHZ);
    localparam logic [3:0]       CreditMax = 4'(CREDIT_MAX);

    logic [7:0]       r_cpuspeed;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_exp_acc;
    logic [ACC_W-1:0] r_custom;
    logic [3:0]       r_credit;
    logic             r_phi_tick;

    logic [7:0]       w_speed_next;
    logic [ACC_W-1:0] w_inc;
    logic [ACC_W-1:0] w_acc_sum;
    logic             w_carry;
    logic             w_paced;
    logic             w_tick;
    logic             w_ready;
    logic             w_consume;
    logic             w_mode_change;
    logic [4:0]       w_credit_sum;
    logic [3:0]       w_credit_next;

    // Mode code from the override inputs, custom pace, then legacy selects
    always_comb begin
        w_speed_next = SpeedFull;
        if (!bus.hypervisor_mode && bus.speed_gate && !bus.force_fast) begin
            if (bus.custom_en && (r_custom != '0)) begin
                w_speed_next = SpeedCustom;
            end else begin
                case ({bus.vicii_2mhz, bus.viciii_fast, bus.viciv_fast})
                    3'b100, 3'b101: w_speed_next = Speed1;
                    3'b110, 3'b010: w_speed_next = Speed3p5;
                    3'b000:         w_speed_next = Speed2;
                    default:        w_speed_next = SpeedFull;
                endcase
            end
        end
    end

    // Increment follows the registered mode, so a new mode paces from its first cycle
    always_comb begin
        case (r_cpuspeed)
            Speed1:      w_inc = Inc1;
            Speed2:      w_inc = Inc2;
            Speed3p5:    w_inc = Inc3p5;
            SpeedCustom: w_inc = r_custom;
            default:     w_inc = '0;
        endcase
    end

    assign {w_carry, w_acc_sum} = {1'b0, r_acc} + {1'b0, w_inc};
    assign w_paced       = (r_cpuspeed != SpeedFull);
    assign w_tick        = w_carry & w_paced;
    assign w_mode_change = (w_speed_next != r_cpuspeed);

    // Reset forces the full-speed view so the CPU is never stalled by stale credit
    assign w_ready   = bus.bus_ready & ~bus.mapper_busy
                     & (reset | ~w_paced | (r_credit != 4'd0));
    assign w_consume = w_ready & w_paced;

    // Credit can never underflow: consume needs nonzero credit in a paced mode
    assign w_credit_sum  = {1'b0, r_credit} + {4'd0, w_tick} - {4'd0, w_consume};
    assign w_credit_next = (w_credit_sum > {1'b0, CreditMax}) ? CreditMax : w_credit_sum[3:0];

    // Mode, custom increment, pacing accumulator, credit and the phi0 accumulator
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpuspeed <= SpeedFull;
            r_acc      <= '0;
            r_exp_acc  <= '0;
            r_custom   <= Inc1;
            r_credit   <= 4'd0;
            r_phi_tick <= 1'b0;
        end else begin
            r_cpuspeed <= w_speed_next;
            r_exp_acc  <= r_exp_acc + Inc1;
            if (bus.custom_we) begin
                r_custom <= bus.custom_inc;
            end
            // Full speed or a pending mode switch: restart pacing from a clean phase
            if (!w_paced || w_mode_change) begin
                r_acc      <= '0;
                r_credit   <= 4'd0;
                r_phi_tick <= 1'b0;
            end else begin
                r_acc      <= w_acc_sum;
                r_credit   <= w_credit_next;
                r_phi_tick <= w_tick;
            end
        end
    end

    assign bus.cpu_ready = w_ready;
    assign bus.phi0      = ~reset & r_exp_acc[ACC_W-1];
    assign bus.phi_tick  = r_phi_tick;
    assign bus.cpuspeed  = r_cpuspeed;
    assign bus.credit    = r_credit;
endmodule

// File: tb/tb_m65_speed_governor.sv
// Bench for m65_speed_governor: directed pacing scenarios with literal
// expectations, a randomized run checked every cycle against a reference
// model, and a default-parameter instance counting 1 MHz ticks over 65536 cycles.
module tb_m65_speed_governor;
    localparam int ACC_W   = 16;
    localparam int T_INC1  = 16384;
    localparam int T_INC2  = 3913;
    localparam int T_INC35 = 6848;
    localparam int T_CMAX  = 2;
    localparam int MOD     = 1 << ACC_W;

    logic clk;
    logic rst;
    logic rst2;

    int n_vec;
    int n_err;
    bit done2;

    m65_speed_governor_if #(.ACC_W(ACC_W)) g ();
    m65_speed_governor_if #(.ACC_W(16))    g2 ();

    m65_speed_governor #(
        .ACC_W      (ACC_W),
        .INC_1MHZ   (T_INC1),
        .INC_2MHZ   (T_INC2),
        .INC_3P5MHZ (T_INC35),
        .CREDIT_MAX (T_CMAX)
    ) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (g)
    );

    m65_speed_governor u_dut_dflt (
        .clk   (clk),
        .reset (rst2),
        .bus   (g2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at t=%0t",
                     nm, got, got, want, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Legacy select table indexed by {vicii_2mhz, viciii_fast, viciv_fast}
    int legacy_tab [8] = '{'h02, 'h50, 'h04, 'h50, 'h01, 'h01, 'h04, 'h50};

    int m_speed, m_acc, m_exp, m_custom, m_credit;
    bit m_tick, m_valid;

    function automatic int mode_of(input int cust);
        if (g.hypervisor_mode || !g.speed_gate || g.force_fast) return 'h50;
        if (g.custom_en && cust != 0) return 'hC0;
        return legacy_tab[{g.vicii_2mhz, g.viciii_fast, g.viciv_fast}];
    endfunction

    function automatic int pace_of(input int spd, input int cust);
        if (spd == 'h01) return T_INC1;
        if (spd == 'h02) return T_INC2;
        if (spd == 'h04) return T_INC35;
        if (spd == 'hC0) return cust;
        return 0;
    endfunction

    always @(posedge clk) begin : ref_model
        int nxt, sum, cr;
        bit paced, tk, rdy;
        if (rst) begin
            m_speed  <= 'h50;
            m_acc    <= 0;
            m_exp    <= 0;
            m_custom <= T_INC1;
            m_credit <= 0;
            m_tick   <= 1'b0;
            m_valid  <= 1'b1;
        end else if (m_valid) begin
            nxt   = mode_of(m_custom);
            paced = (m_speed != 'h50);
            sum   = m_acc + pace_of(m_speed, m_custom);
            tk    = paced && (sum >= MOD);
            rdy   = g.bus_ready && !g.mapper_busy && (!paced || m_credit != 0);
            cr    = m_credit + int'(tk) - int'(rdy && paced);
            if (cr > T_CMAX) cr = T_CMAX;
            if (!paced || nxt != m_speed) begin
                m_acc    <= 0;
                m_credit <= 0;
                m_tick   <= 1'b0;
            end else begin
                m_acc    <= sum % MOD;
                m_credit <= cr;
                m_tick   <= tk;
            end
            m_exp <= (m_exp + T_INC1) % MOD;
            if (g.custom_we) m_custom <= int'(g.custom_inc);
            m_speed <= nxt;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin : compare
        bit exp_ready, exp_phi0;
        if (m_valid) begin
            exp_ready = g.bus_ready && !g.mapper_busy
                        && (rst || m_speed == 'h50 || m_credit != 0);
            exp_phi0  = !rst && (m_exp >= MOD / 2);
            chk("model_cpu_ready", int'(g.cpu_ready), int'(exp_ready));
            chk("model_phi0",      int'(g.phi0),      int'(exp_phi0));
            chk("model_phi_tick",  int'(g.phi_tick),  int'(m_tick));
            chk("model_cpuspeed",  int'(g.cpuspeed),  m_speed);
            chk("model_credit",    int'(g.credit),    m_credit);
        end
    end

    // ---------------- default-parameter 1 MHz pace count ----------------
    initial begin : pace_1mhz
        bit found;
        int cnt, last, bad_gap;
        rst2 = 1'b1;
        g2.force_fast = 0; g2.hypervisor_mode = 0; g2.speed_gate = 1;
        g2.vicii_2mhz = 1; g2.viciii_fast = 0; g2.viciv_fast = 0;
        g2.custom_en = 0; g2.custom_we = 0; g2.custom_inc = '0;
        g2.bus_ready = 1; g2.mapper_busy = 0;
        repeat (2) @(posedge clk);
        #2 rst2 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (g2.cpuspeed == 8'h01) found = 1'b1;
        end
        if (!found) begin
            chk("dflt_enter_1mhz", int'(g2.cpuspeed), 'h01);
        end else begin
            cnt = 0; last = -1; bad_gap = 0;
            for (int k = 1; k <= 65536; k++) begin
                @(negedge clk);
                if (g2.phi_tick) begin
                    if (last >= 0 && (k - last < 33 || k - last > 34)) bad_gap++;
                    last = k;
                    cnt++;
                end
            end
            chk("dflt_ticks_per_65536", cnt, 1957);
            chk("dflt_bad_tick_gaps", bad_gap, 0);
        end
        done2 = 1'b1;
    end

    // ---------------- directed + random stimulus ----------------
    initial begin : stim
        int pe;
        rst = 1'b1;
        g.force_fast = 0; g.hypervisor_mode = 0; g.speed_gate = 1;
        g.vicii_2mhz = 1; g.viciii_fast = 0; g.viciv_fast = 0;
        g.custom_en = 0; g.custom_we = 0; g.custom_inc = '0;
        g.bus_ready = 1; g.mapper_busy = 0;
        @(posedge clk); #2;
        @(posedge clk); #2 rst = 1'b0;

        // 1 MHz pace at INC 16384: tick every 4th cycle, one grant per tick
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            pe = (k >= 6 && (k - 6) % 4 == 0) ? 1 : 0;
            chk("d1_phi_tick",  int'(g.phi_tick),  pe);
            chk("d1_cpu_ready", int'(g.cpu_ready), (k == 1) ? 1 : pe);
            chk("d1_cpuspeed",  int'(g.cpuspeed),  (k == 1) ? 'h50 : 'h01);
            chk("d1_credit",    int'(g.credit),    pe);
        end

        // Bus stalled: credit saturates at 2, then two back-to-back grants
        @(posedge clk); #2 g.bus_ready = 0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("d2_credit_sat", int'(g.credit), 2);
        @(posedge clk); #2 g.bus_ready = 1;
        @(negedge clk); chk("d2_ready_first",  int'(g.cpu_ready), 1);
        @(negedge clk); chk("d2_ready_second", int'(g.cpu_ready), 1);
        @(negedge clk); chk("d2_ready_third",  int'(g.cpu_ready), 0);
        chk("d2_credit_drained", int'(g.credit), 0);

        // Hypervisor pulse with one credit pending
        @(posedge clk); #2 g.hypervisor_mode = 1;
        @(negedge clk); chk("d3_credit_before", int'(g.credit), 1);
        @(posedge clk); #2 g.hypervisor_mode = 0;
        @(negedge clk);
        chk("d3_cpuspeed_hyp", int'(g.cpuspeed), 'h50);
        chk("d3_credit_hyp",   int'(g.credit),   0);
        chk("d3_ready_hyp",    int'(g.cpu_ready), 1);
        for (int c = 32; c <= 36; c++) begin
            @(negedge clk);
            chk("d3_restart_tick", int'(g.phi_tick), (c == 36) ? 1 : 0);
        end

        // Custom pace of 32768: mode 0xC0 next cycle, tick every 2 cycles
        @(posedge clk); #2 g.custom_we = 1; g.custom_inc = 16'd32768; g.custom_en = 1;
        @(posedge clk); #2 g.custom_we = 0;
        @(negedge clk); chk("d4_cpuspeed_custom", int'(g.cpuspeed), 'hC0);
        for (int c = 39; c <= 44; c++) begin
            @(negedge clk);
            chk("d4_custom_tick", int'(g.phi_tick), (c % 2 == 0) ? 1 : 0);
        end

        // Custom increment of zero falls back to the legacy decode
        @(posedge clk); #2 g.custom_we = 1; g.custom_inc = '0;
        @(posedge clk); #2 g.custom_we = 0;
        @(negedge clk);
        for (int c = 47; c <= 52; c++) begin
            @(negedge clk);
            chk("d5_legacy_speed", int'(g.cpuspeed), 'h01);
        end

        // Reset from 3.5 MHz with credit 2, racing a custom write
        @(posedge clk); #2 g.vicii_2mhz = 0; g.viciii_fast = 1; g.bus_ready = 0;
        repeat (40) @(negedge clk);
        chk("d6_speed_35", int'(g.cpuspeed), 'h04);
        chk("d6_credit_2", int'(g.credit),   2);
        @(posedge clk); #2 rst = 1; g.bus_ready = 1; g.custom_we = 1; g.custom_inc = 16'd777;
        @(negedge clk);
        chk("d6_ready_in_reset", int'(g.cpu_ready), 1);
        chk("d6_phi0_in_reset",  int'(g.phi0),      0);
        @(posedge clk); #2 rst = 0; g.custom_we = 0;
        @(negedge clk);
        chk("d6_speed_after",  int'(g.cpuspeed), 'h50);
        chk("d6_credit_after", int'(g.credit),   0);
        chk("d6_tick_after",   int'(g.phi_tick), 0);
        chk("d6_phi0_after",   int'(g.phi0),     0);

        // Randomized run; mode inputs change rarely so pacing has time to develop
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) g.hypervisor_mode = ~g.hypervisor_mode;
            if ($urandom_range(0, 49) == 0) g.force_fast = ~g.force_fast;
            if ($urandom_range(0, 29) == 0) g.speed_gate = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) begin
                g.vicii_2mhz  = $urandom_range(0, 1);
                g.viciii_fast = $urandom_range(0, 1);
                g.viciv_fast  = $urandom_range(0, 1);
            end
            if ($urandom_range(0, 39) == 0) g.custom_en = ~g.custom_en;
            g.custom_we = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 3))
                0:       g.custom_inc = '0;
                1:       g.custom_inc = 16'd16384;
                2:       g.custom_inc = 16'd32768;
                default: g.custom_inc = 16'($urandom_range(1, 65535));
            endcase
            g.bus_ready   = ($urandom_range(0, 9) < 7);
            g.mapper_busy = ($urandom_range(0, 9) < 2);
        end
        @(posedge clk); #2 rst = 0; g.custom_we = 0;

        for (int i = 0; i < 100000 && !done2; i++) @(posedge clk);
        if (!done2) chk("dflt_pace_timeout", 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
